// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the arbiter FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'h0;
    localparam logic [2:0] ALU_OR   = 3'h1;
    localparam logic [2:0] ALU_ADD  = 3'h2;
    localparam logic [2:0] ALU_XOR  = 3'h3;
    localparam logic [2:0] ALU_NOR  = 3'h4;
    localparam logic [2:0] ALU_SRL  = 3'h5;
    localparam logic [2:0] ALU_SUB  = 3'h6;
    localparam logic [2:0] ALU_SLTU = 3'h7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
// ALU_ARB_FIXED_PRIO_EN selects plain lowest-index-wins priority and ignores ptr.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int unsigned pos;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            pos = k;
`else
            pos = (32'(ptr) + k) % NREQ;
`endif
            if (!any && req[IDXW'(pos)]) begin
                gnt[IDXW'(pos)] = 1'b1;
                idx             = IDXW'(pos);
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ valid/ready requesters (IDLE -> ISSUE -> RESP).
// Build with ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       io_req_valid,
    output logic [NREQ-1:0]       io_req_ready,
    input  logic [3*NREQ-1:0]     io_req_op,
    input  logic [WIDTH*NREQ-1:0] io_req_a,
    input  logic [WIDTH*NREQ-1:0] io_req_b,
    output logic [NREQ-1:0]       io_resp_valid,
    input  logic [NREQ-1:0]       io_resp_ready,
    output logic [WIDTH-1:0]      io_resp_data,
    output logic                  io_resp_zero,
    output logic [2:0]            io_alu_op,
    output logic [WIDTH-1:0]      io_alu_a,
    output logic [WIDTH-1:0]      io_alu_b,
    input  logic [WIDTH-1:0]      io_alu_out,
    input  logic                  io_alu_zero
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   owner;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic              zero_q;
    logic [NREQ-1:0]   resp_valid_q;

    logic [NREQ-1:0]   gnt;
    logic [IDXW-1:0]   gnt_idx;
    logic              gnt_any;
    logic [2:0]        sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [IDXW-1:0]   next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req (io_req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Operand mux for the winning requester
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDXW'(i)) begin
                sel_op = io_req_op[3*i +: 3];
                sel_a  = io_req_a[WIDTH*i +: WIDTH];
                sel_b  = io_req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    assign next_ptr = (owner == IDXW'(NREQ - 1)) ? '0 : owner + IDXW'(1);

    // Accept is only possible from IDLE; reset suppresses a same-cycle handshake
    assign io_req_ready  = (state == IDLE && !reset) ? gnt : '0;
    assign io_resp_valid = resp_valid_q;
    assign io_resp_data  = res_q;
    assign io_resp_zero  = zero_q;
    assign io_alu_op     = op_q;
    assign io_alu_a      = a_q;
    assign io_alu_b      = b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        owner <= gnt_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_q        <= io_alu_out;
                    zero_q       <= io_alu_zero;
                    resp_valid_q <= NREQ'(1) << owner;
                    state        <= RESP;
                end
                RESP: begin
                    if (io_resp_ready[owner]) begin
                        resp_valid_q <= '0;
                        rr_ptr       <= next_ptr;
                        state        <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model attached.
// Expected grant order follows ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       io_req_valid;
    logic [NREQ-1:0]       io_req_ready;
    logic [3*NREQ-1:0]     io_req_op;
    logic [WIDTH*NREQ-1:0] io_req_a;
    logic [WIDTH*NREQ-1:0] io_req_b;
    logic [NREQ-1:0]       io_resp_valid;
    logic [NREQ-1:0]       io_resp_ready;
    logic [WIDTH-1:0]      io_resp_data;
    logic                  io_resp_zero;
    logic [2:0]            io_alu_op;
    logic [WIDTH-1:0]      io_alu_a;
    logic [WIDTH-1:0]      io_alu_b;
    logic [WIDTH-1:0]      io_alu_out;
    logic                  io_alu_zero;

    int errors = 0;
    int checks = 0;
    logic [NREQ-1:0] exp_g;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_op     (io_req_op),
        .io_req_a      (io_req_a),
        .io_req_b      (io_req_b),
        .io_resp_valid (io_resp_valid),
        .io_resp_ready (io_resp_ready),
        .io_resp_data  (io_resp_data),
        .io_resp_zero  (io_resp_zero),
        .io_alu_op     (io_alu_op),
        .io_alu_a      (io_alu_a),
        .io_alu_b      (io_alu_b),
        .io_alu_out    (io_alu_out),
        .io_alu_zero   (io_alu_zero)
    );

    // Behavioural ALU standing in for the real datapath
    always_comb begin
        case (io_alu_op)
            ALU_AND:  io_alu_out = io_alu_a & io_alu_b;
            ALU_OR:   io_alu_out = io_alu_a | io_alu_b;
            ALU_ADD:  io_alu_out = io_alu_a + io_alu_b;
            ALU_XOR:  io_alu_out = io_alu_a ^ io_alu_b;
            ALU_NOR:  io_alu_out = ~(io_alu_a | io_alu_b);
            ALU_SRL:  io_alu_out = io_alu_a >> io_alu_b[4:0];
            ALU_SUB:  io_alu_out = io_alu_a - io_alu_b;
            default:  io_alu_out = (io_alu_a < io_alu_b) ? 32'd1 : 32'd0;
        endcase
        io_alu_zero = (io_alu_out == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        io_req_op[3*r +: 3]       = op;
        io_req_a[WIDTH*r +: WIDTH] = a;
        io_req_b[WIDTH*r +: WIDTH] = b;
    endtask

    initial begin
        reset         = 1'b1;
        io_req_valid  = '0;
        io_req_op     = '0;
        io_req_a      = '0;
        io_req_b      = '0;
        io_resp_ready = '0;
        tick();
        tick();
        chk("rst_ready", 64'(io_req_ready), 64'h0);
        chk("rst_resp_valid", 64'(io_resp_valid), 64'h0);
        chk("rst_data", 64'(io_resp_data), 64'h0);
        chk("rst_alu_a", 64'(io_alu_a), 64'h0);
        reset = 1'b0;

        // 1: ADD 5+7 from requester 0
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        io_req_valid = 2'b01;
        #1 chk("t1_ready", 64'(io_req_ready), 64'h1);
        tick();
        io_req_valid = 2'b00;
        chk("t1_issue_ready", 64'(io_req_ready), 64'h0);
        chk("t1_alu_a", 64'(io_alu_a), 64'd5);
        chk("t1_alu_op", 64'(io_alu_op), 64'd2);
        chk("t1_issue_valid", 64'(io_resp_valid), 64'h0);
        tick();
        chk("t1_resp_valid", 64'(io_resp_valid), 64'h1);
        chk("t1_data", 64'(io_resp_data), 64'd12);
        chk("t1_zero", 64'(io_resp_zero), 64'd0);
        io_resp_ready = 2'b01;
        tick();
        io_resp_ready = 2'b00;
        chk("t1_done_valid", 64'(io_resp_valid), 64'h0);

        // 2: SUB 9-9 from requester 1, stalled response
        set_req(1, ALU_SUB, 32'd9, 32'd9);
        io_req_valid = 2'b10;
        #1 chk("t2_ready", 64'(io_req_ready), 64'h2);
        tick();
        io_req_valid = 2'b00;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_valid", 64'(io_resp_valid), 64'h2);
            chk("t2_hold_data", 64'(io_resp_data), 64'd0);
            chk("t2_hold_zero", 64'(io_resp_zero), 64'd1);
            tick();
        end
        io_resp_ready = 2'b10;
        tick();
        io_resp_ready = 2'b00;
        chk("t2_done_valid", 64'(io_resp_valid), 64'h0);

        // 3: both requesters continuously valid for four transactions
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        set_req(1, ALU_XOR, 32'd6, 32'd3);
        io_req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
            #1 chk("t3_grant", 64'(io_req_ready), 64'(exp_g));
            tick();
            tick();
            chk("t3_resp_valid", 64'(io_resp_valid), 64'(exp_g));
            chk("t3_data", 64'(io_resp_data), (exp_g == 2'b01) ? 64'd3 : 64'd5);
            io_resp_ready = exp_g;
            tick();
            io_resp_ready = 2'b00;
        end
        io_req_valid = 2'b00;

        // 4: SLTU and SRL boundary operands
        set_req(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        io_req_valid = 2'b01;
        tick();
        io_req_valid = 2'b00;
        tick();
        chk("t4_sltu_data", 64'(io_resp_data), 64'd0);
        chk("t4_sltu_zero", 64'(io_resp_zero), 64'd1);
        io_resp_ready = 2'b01;
        tick();
        io_resp_ready = 2'b00;
        set_req(0, ALU_SRL, 32'h8000_0000, 32'h21);
        io_req_valid = 2'b01;
        tick();
        io_req_valid = 2'b00;
        tick();
        chk("t4_srl_data", 64'(io_resp_data), 64'h4000_0000);
        io_resp_ready = 2'b01;
        tick();
        io_resp_ready = 2'b00;

        // 5: reset during RESP abandons the response
        set_req(0, ALU_OR, 32'hF0, 32'h0F);
        io_req_valid = 2'b01;
        tick();
        io_req_valid = 2'b00;
        tick();
        chk("t5_resp_valid", 64'(io_resp_valid), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_abandon_valid", 64'(io_resp_valid), 64'h0);
        chk("t5_abandon_data", 64'(io_resp_data), 64'h0);
        io_req_valid = 2'b01;
        #1 chk("t5_regrant", 64'(io_req_ready), 64'h1);
        tick();
        io_req_valid = 2'b00;
        tick();
        chk("t5_data", 64'(io_resp_data), 64'hFF);
        io_resp_ready = 2'b01;
        tick();
        io_resp_ready = 2'b00;

        // 6: non-owner resp_ready ignored; pointer moves only on owner handshake
        set_req(1, ALU_AND, 32'hC, 32'hA);
        io_req_valid = 2'b10;
        tick();
        io_req_valid = 2'b00;
        tick();
        io_resp_ready = 2'b10;
        tick();
        io_resp_ready = 2'b00;
        set_req(0, ALU_NOR, 32'h0, 32'h0);
        io_req_valid = 2'b01;
        tick();
        io_req_valid = 2'b00;
        tick();
        io_resp_ready = 2'b10;
        tick();
        chk("t6_ignored_valid", 64'(io_resp_valid), 64'h1);
        tick();
        chk("t6_still_valid", 64'(io_resp_valid), 64'h1);
        chk("t6_data", 64'(io_resp_data), 64'hFFFF_FFFF);
        io_resp_ready = 2'b01;
        tick();
        io_resp_ready = 2'b00;
        chk("t6_done_valid", 64'(io_resp_valid), 64'h0);
        io_req_valid = 2'b11;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = 2'b01;
`else
        exp_g = 2'b10;
`endif
        #1 chk("t6_next_grant", 64'(io_req_ready), 64'(exp_g));
        io_req_valid = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
